median_select_ctrl: RTL
=======================

Name: median_select_ctrl

Overview:
- Control stage directly downstream of the pixel fill/partition stage of the median quick-select loop.
- Each time fill_buffers completes a pass, this block samples the lower/equal/larger counts and the min/max statistics.
- It then either declares the median found or issues the next pass command: new pivot, new buffer size, new target rank, and which partition to keep.
- It also starts each frame and drives the `sending` back-pressure input of fill_buffers.

Parameters:
- BUFF_SIZE, 32, maximum pixels per median window.
- BUFF_SIZE_BIT, $clog2(BUFF_SIZE)+1, width of all size and rank fields.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- start_valid  in  1  new frame request.
- start_size  in  BUFF_SIZE_BIT  pixels in the new frame (N).
- start_ready  out  1  high in IDLE when no frame is active.
- up_next  in  1  fill pass complete; statistics valid this cycle.
- lower_size, equal_size, larger_size  in  BUFF_SIZE_BIT each  partition counts.
- min_lower, max_lower, min_larger, max_larger  in  8 each  partition extremes.
- sending  out  1  to fill_buffers: result of the previous pass not yet consumed.
- out_pivot  out  8  next pivot.
- out_buff_size  out  BUFF_SIZE_BIT  next pass size.
- out_k  out  BUFF_SIZE_BIT  next 0-based target rank.
- keep_sel  out  2  2'b11 all (source), 2'b01 lower, 2'b10 larger.
- out_valid  out  1  pass command valid.
- out_ready  in  1  consumer sampled the pass command.
- median_out  out  8  median result.
- median_valid  out  1  result valid.
- median_ready  in  1  result consumed.
- err_overrun  out  1  sticky error flag.

Behaviour:
- **Reset:** rst_n low at a clk edge sets
  - state=IDLE, active=0;
  - all data outputs 0, all valids 0;
  - sending=0, err_overrun=0.
  - Reset in any state, including with out_valid or median_valid high, aborts the frame without completing the handshake.
- **FSM states:** IDLE, DECIDE, ISSUE, DONE.
- **IDLE, start:**
  - Accept on start_valid & start_ready.
  - If start_size==0: set err_overrun and remain IDLE.
  - Otherwise: register pivot=8'd128, buff_size=N, k=(N-1)>>1, keep_sel=2'b11, active=1; go to ISSUE.
  - out_valid is visible the cycle after the handshake.
- **IDLE, up_next:**
  - With active=1: capture all statistics plus the current pivot and k into internal registers; go to DECIDE.
  - With active=0: up_next is ignored.
- **DECIDE** (one cycle; L=lower, E=equal, sums at BUFF_SIZE_BIT+1 bits):
  - If k<L:
    - if L==1 or min_lower==max_lower: median=min_lower, go to DONE;
    - else pivot=(min_lower+max_lower)>>1 (9-bit sum, floor), size=L, k unchanged, keep_sel=01, go to ISSUE.
  - Else if k<L+E: median=captured pivot, go to DONE.
  - Else: k'=k-L-E, G=larger_size.
    - If G==1 or min_larger==max_larger: median=min_larger, go to DONE.
    - Else pivot=(min_larger+max_larger)>>1, size=G, k=k', keep_sel=10, go to ISSUE.
- **Latency:** up_next at cycle t gives out_valid or median_valid asserted in cycle t+2.
- **ISSUE:**
  - out_* held stable while out_valid=1.
  - On out_valid & out_ready: clear out_valid, go to IDLE.
- **DONE:**
  - median_out held while median_valid=1.
  - On median_valid & median_ready: clear median_valid and active, go to IDLE.
- **sending:**
  - High from the cycle after up_next is captured until the out_ready or median_ready handshake completes.
  - Also high in ISSUE after a start.
- **Overrun and start rules:**
  - up_next while state≠IDLE sets err_overrun (sticky until reset); the event is dropped.
  - start_valid while active is not accepted (start_ready=0).
- **Invariant:** the kept partition always leaves strictly fewer distinct values, which guarantees termination.

Decomposition:
- **Shared package median_pkg:**
  - BUFF_SIZE default;
  - FSM state encoding;
  - keep_sel codes KEEP_ALL, KEEP_LOW, KEEP_LARG;
  - initial pivot constant 8'd128.
- **Sub-module select_decide:** purely combinational. Takes the captured statistics, pivot and k; returns found, median, pivot, size, k, keep_sel. It keeps the FSM file small and is unit-testable alone.

Test Plan:
- **Start:** start_size=5 → one cycle later out_pivot=128, out_buff_size=5, out_k=2, keep_sel=11, out_valid=1, sending=1; out_ready pulse → IDLE.
- **Lower recursion:** k=2, L=5, E=0, G=0, min_lower=10, max_lower=50, up_next → at t+2 out_pivot=30, size=5, k=2, keep_sel=01.
- **Equal hit and larger recursion:**
  - pivot=30, k=2, L=2, E=1 → median_out=30, median_valid at t+2.
  - Separately k=4, L=2, E=1, G=2, min_larger=40, max_larger=50 → pivot=45, size=2, k=1, keep_sel=10.
- **Singleton and flat partitions:**
  - k=0, L=1, min_lower=7 → median=7.
  - k=3, L=0, E=0, G=4, min_larger=max_larger=99 → median=99.
- **Back-pressure and overrun:** hold out_ready=0 for 3 cycles → outputs stable, sending=1; up_next pulse in ISSUE → err_overrun=1, outputs unchanged.
- **Reset mid-operation:** rst_n=0 for one edge while out_valid=1 → next cycle all outputs 0, state IDLE, start_ready=1.

Source files
------------

// File: rtl/median_pkg.sv
// Shared constants and types for the median quick-select control stage.
package median_pkg;

  parameter int unsigned BUFF_SIZE_DEFAULT = 32;

  typedef enum logic [1:0] {
    StIdle,
    StDecide,
    StIssue,
    StDone
  } state_e;

  localparam logic [1:0] KEEP_ALL  = 2'b11;
  localparam logic [1:0] KEEP_LOW  = 2'b01;
  localparam logic [1:0] KEEP_LARG = 2'b10;

  localparam logic [7:0] PIVOT_INIT = 8'd128;

endpackage

// File: rtl/median_select_ctrl_if.sv
// Bundle of frame-start, fill statistics, pass command and median result signals.
interface median_select_ctrl_if
  import median_pkg::*;
#(
  parameter int unsigned BUFF_SIZE_BIT = $clog2(BUFF_SIZE_DEFAULT) + 1
);

  logic                     start_valid;
  logic [BUFF_SIZE_BIT-1:0] start_size;
  logic                     start_ready;

  logic                     up_next;
  logic [BUFF_SIZE_BIT-1:0] lower_size;
  logic [BUFF_SIZE_BIT-1:0] equal_size;
  logic [BUFF_SIZE_BIT-1:0] larger_size;
  logic [7:0]               min_lower;
  logic [7:0]               max_lower;
  logic [7:0]               min_larger;
  logic [7:0]               max_larger;
  logic                     sending;

  logic [7:0]               out_pivot;
  logic [BUFF_SIZE_BIT-1:0] out_buff_size;
  logic [BUFF_SIZE_BIT-1:0] out_k;
  logic [1:0]               keep_sel;
  logic                     out_valid;
  logic                     out_ready;

  logic [7:0]               median_out;
  logic                     median_valid;
  logic                     median_ready;

  logic                     err_overrun;

  // Environment side: frame source, fill_buffers and downstream consumers.
  modport master (
    output start_valid, start_size, up_next, lower_size, equal_size, larger_size,
           min_lower, max_lower, min_larger, max_larger, out_ready, median_ready,
    input  start_ready, sending, out_pivot, out_buff_size, out_k, keep_sel, out_valid,
           median_out, median_valid, err_overrun
  );

  // Control-stage side.
  modport slave (
    input  start_valid, start_size, up_next, lower_size, equal_size, larger_size,
           min_lower, max_lower, min_larger, max_larger, out_ready, median_ready,
    output start_ready, sending, out_pivot, out_buff_size, out_k, keep_sel, out_valid,
           median_out, median_valid, err_overrun
  );

endinterface

// File: rtl/median_select_ctrl_select_decide.sv
// Combinational quick-select step: picks the partition holding rank k, or reports the median.
module select_decide
  import median_pkg::*;
#(
  parameter int unsigned W = 6
) (
  input  logic [W-1:0] k_i,
  input  logic [7:0]   pivot_i,
  input  logic [W-1:0] lower_i,
  input  logic [W-1:0] equal_i,
  input  logic [W-1:0] larger_i,
  input  logic [7:0]   min_lower_i,
  input  logic [7:0]   max_lower_i,
  input  logic [7:0]   min_larger_i,
  input  logic [7:0]   max_larger_i,
  output logic         found_o,
  output logic [7:0]   median_o,
  output logic [7:0]   pivot_o,
  output logic [W-1:0] size_o,
  output logic [W-1:0] k_o,
  output logic [1:0]   keep_o
);

  logic [W:0] le_sum;
  logic [7:0] mid_lower;
  logic [7:0] mid_larger;

  assign le_sum     = {1'b0, lower_i} + {1'b0, equal_i};
  // Midpoints use a 9-bit sum so 255+255 does not wrap.
  assign mid_lower  = 8'(({1'b0, min_lower_i} + {1'b0, max_lower_i}) >> 1);
  assign mid_larger = 8'(({1'b0, min_larger_i} + {1'b0, max_larger_i}) >> 1);

  always_comb begin
    found_o  = 1'b0;
    median_o = 8'd0;
    pivot_o  = pivot_i;
    size_o   = '0;
    k_o      = k_i;
    keep_o   = KEEP_ALL;
    if (k_i < lower_i) begin
      if (lower_i == W'(1) || min_lower_i == max_lower_i) begin
        found_o  = 1'b1;
        median_o = min_lower_i;
      end else begin
        pivot_o = mid_lower;
        size_o  = lower_i;
        keep_o  = KEEP_LOW;
      end
    end else if ({1'b0, k_i} < le_sum) begin
      found_o  = 1'b1;
      median_o = pivot_i;
    end else begin
      if (larger_i == W'(1) || min_larger_i == max_larger_i) begin
        found_o  = 1'b1;
        median_o = min_larger_i;
      end else begin
        pivot_o = mid_larger;
        size_o  = larger_i;
        k_o     = W'({1'b0, k_i} - le_sum);
        keep_o  = KEEP_LARG;
      end
    end
  end

endmodule

// File: rtl/median_select_ctrl.sv
// Median quick-select loop controller: starts frames, evaluates each fill pass, issues the next.
module median_select_ctrl
  import median_pkg::*;
#(
  parameter int unsigned BUFF_SIZE     = BUFF_SIZE_DEFAULT,
  parameter int unsigned BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1
) (
  input logic                 clk,
  input logic                 rst_n,
  median_select_ctrl_if.slave bus
);

  localparam int unsigned W = BUFF_SIZE_BIT;

  state_e       state_q;
  logic         active_q;
  logic [7:0]   pivot_q;
  logic [W-1:0] size_q;
  logic [W-1:0] k_q;
  logic [1:0]   keep_q;
  logic         out_valid_q;
  logic [7:0]   median_q;
  logic         median_valid_q;
  logic         sending_q;
  logic         err_q;

  logic [W-1:0] cap_lower_q;
  logic [W-1:0] cap_equal_q;
  logic [W-1:0] cap_larger_q;
  logic [7:0]   cap_min_lo_q;
  logic [7:0]   cap_max_lo_q;
  logic [7:0]   cap_min_lg_q;
  logic [7:0]   cap_max_lg_q;
  logic [7:0]   cap_pivot_q;
  logic [W-1:0] cap_k_q;

  logic         dec_found;
  logic [7:0]   dec_median;
  logic [7:0]   dec_pivot;
  logic [W-1:0] dec_size;
  logic [W-1:0] dec_k;
  logic [1:0]   dec_keep;

  logic         start_ready;
  logic         start_accept;

  assign start_ready  = (state_q == StIdle) && !active_q;
  assign start_accept = bus.start_valid && start_ready;

  assign bus.start_ready   = start_ready;
  assign bus.sending       = sending_q;
  assign bus.out_pivot     = pivot_q;
  assign bus.out_buff_size = size_q;
  assign bus.out_k         = k_q;
  assign bus.keep_sel      = keep_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.median_out    = median_q;
  assign bus.median_valid  = median_valid_q;
  assign bus.err_overrun   = err_q;

  select_decide #(
    .W (W)
  ) u_decide (
    .k_i          (cap_k_q),
    .pivot_i      (cap_pivot_q),
    .lower_i      (cap_lower_q),
    .equal_i      (cap_equal_q),
    .larger_i     (cap_larger_q),
    .min_lower_i  (cap_min_lo_q),
    .max_lower_i  (cap_max_lo_q),
    .min_larger_i (cap_min_lg_q),
    .max_larger_i (cap_max_lg_q),
    .found_o      (dec_found),
    .median_o     (dec_median),
    .pivot_o      (dec_pivot),
    .size_o       (dec_size),
    .k_o          (dec_k),
    .keep_o       (dec_keep)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      active_q       <= 1'b0;
      pivot_q        <= 8'd0;
      size_q         <= '0;
      k_q            <= '0;
      keep_q         <= 2'b00;
      out_valid_q    <= 1'b0;
      median_q       <= 8'd0;
      median_valid_q <= 1'b0;
      sending_q      <= 1'b0;
      err_q          <= 1'b0;
      cap_lower_q    <= '0;
      cap_equal_q    <= '0;
      cap_larger_q   <= '0;
      cap_min_lo_q   <= 8'd0;
      cap_max_lo_q   <= 8'd0;
      cap_min_lg_q   <= 8'd0;
      cap_max_lg_q   <= 8'd0;
      cap_pivot_q    <= 8'd0;
      cap_k_q        <= '0;
    end else begin
      // A pass result arriving while the previous one is still in flight is dropped.
      if (bus.up_next && state_q != StIdle) begin
        err_q <= 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (start_accept) begin
            if (bus.start_size == '0) begin
              err_q <= 1'b1;
            end else begin
              pivot_q     <= PIVOT_INIT;
              size_q      <= bus.start_size;
              k_q         <= (bus.start_size - W'(1)) >> 1;
              keep_q      <= KEEP_ALL;
              active_q    <= 1'b1;
              out_valid_q <= 1'b1;
              sending_q   <= 1'b1;
              state_q     <= StIssue;
            end
          end else if (bus.up_next && active_q) begin
            cap_lower_q  <= bus.lower_size;
            cap_equal_q  <= bus.equal_size;
            cap_larger_q <= bus.larger_size;
            cap_min_lo_q <= bus.min_lower;
            cap_max_lo_q <= bus.max_lower;
            cap_min_lg_q <= bus.min_larger;
            cap_max_lg_q <= bus.max_larger;
            cap_pivot_q  <= pivot_q;
            cap_k_q      <= k_q;
            sending_q    <= 1'b1;
            state_q      <= StDecide;
          end
        end
        StDecide: begin
          if (dec_found) begin
            median_q       <= dec_median;
            median_valid_q <= 1'b1;
            state_q        <= StDone;
          end else begin
            pivot_q     <= dec_pivot;
            size_q      <= dec_size;
            k_q         <= dec_k;
            keep_q      <= dec_keep;
            out_valid_q <= 1'b1;
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            sending_q   <= 1'b0;
            state_q     <= StIdle;
          end
        end
        StDone: begin
          if (bus.median_ready) begin
            median_valid_q <= 1'b0;
            active_q       <= 1'b0;
            sending_q      <= 1'b0;
            state_q        <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
